// File: rtl/nios_sys_pio_clkdiv_pkg.sv
// Shared register map constants and address decode helper for the
// programmable clock-divider PIO.
package nios_sys_pio_clkdiv_pkg;

  localparam int unsigned REG_CONTROL      = 0;
  localparam int unsigned REG_STATUS       = 1;
  localparam int unsigned REG_DIVISOR_BASE = 2;

  function automatic logic addr_is_divisor(input logic [31:0] addr, input int unsigned ch);
    return addr == (REG_DIVISOR_BASE + ch);
  endfunction

endpackage

// File: rtl/nios_sys_pio_clkdiv_channel.sv
// One divider channel: counts to divisor-1, emits a one-cycle tick and
// toggles a square wave on every wrap.
module nios_sys_clkdiv_channel
  import nios_sys_pio_clkdiv_pkg::*;
#(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_enable,
  input  logic [DIV_WIDTH-1:0] i_divisor,
  input  logic                 i_restart,
  output logic                 o_fire,
  output logic                 o_tick,
  output logic                 o_sq_out
);

  logic                 w_active;
  logic                 w_wrap;
  logic [DIV_WIDTH-1:0] r_cnt;
  logic                 r_tick;
  logic                 r_sq;

  assign w_active = i_enable & (i_divisor != '0);
  assign w_wrap   = (r_cnt == (i_divisor - DIV_WIDTH'(1)));
  // Tells the register file a tick is being launched on this edge.
  assign o_fire   = w_active & ~i_restart & w_wrap;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
      r_sq   <= 1'b0;
    end else if (i_restart) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (!w_active) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
      r_sq   <= 1'b0;
    end else if (w_wrap) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
      r_sq   <= ~r_sq;
    end else begin
      r_cnt  <= r_cnt + DIV_WIDTH'(1);
      r_tick <= 1'b0;
    end
  end

  assign o_tick   = r_tick;
  assign o_sq_out = r_sq;

endmodule

// File: rtl/nios_sys_pio_clkdiv.sv
// Avalon-MM slave with CHANNELS independent programmable clock dividers:
// register file, sticky status flags and combinational read mux.
module nios_sys_pio_clkdiv
  import nios_sys_pio_clkdiv_pkg::*;
#(
  parameter int          CHANNELS      = 4,
  parameter int          DIV_WIDTH     = 16,
  parameter int          ADDR_WIDTH    = 3,
  parameter int unsigned RESET_DIVISOR = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [CHANNELS-1:0]   tick,
  output logic [CHANNELS-1:0]   sq_out
);

  logic                 w_wr;
  logic                 w_wr_ctrl;
  logic                 w_wr_stat;
  logic [31:0]          w_addr;
  logic [CHANNELS-1:0]  w_wr_div;
  logic [CHANNELS-1:0]  w_restart;
  logic [CHANNELS-1:0]  w_fire;
  logic [CHANNELS-1:0]  w_clear;
  logic [CHANNELS-1:0]  r_enable;
  logic [CHANNELS-1:0]  r_status;
  logic [DIV_WIDTH-1:0] r_div [CHANNELS];

  assign w_wr      = chipselect & ~write_n;
  assign w_addr    = 32'(address);
  assign w_wr_ctrl = w_wr & (w_addr == REG_CONTROL);
  assign w_wr_stat = w_wr & (w_addr == REG_STATUS);
  assign w_clear   = w_wr_stat ? writedata[CHANNELS-1:0] : '0;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    assign w_wr_div[gi]  = w_wr & addr_is_divisor(w_addr, gi);
    // A channel restarts from zero on a divisor write or an enable rise only.
    assign w_restart[gi] = w_wr_div[gi] | (w_wr_ctrl & writedata[gi] & ~r_enable[gi]);

    nios_sys_clkdiv_channel #(
      .DIV_WIDTH (DIV_WIDTH)
    ) u_channel (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_enable  (r_enable[gi]),
      .i_divisor (r_div[gi]),
      .i_restart (w_restart[gi]),
      .o_fire    (w_fire[gi]),
      .o_tick    (tick[gi]),
      .o_sq_out  (sq_out[gi])
    );
  end

  // Status set has priority over a coincident write-1-clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_enable <= '0;
      r_status <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        r_div[i] <= DIV_WIDTH'(RESET_DIVISOR);
      end
    end else begin
      if (w_wr_ctrl) begin
        r_enable <= writedata[CHANNELS-1:0];
      end
      r_status <= w_fire | (r_status & ~w_clear);
      for (int i = 0; i < CHANNELS; i++) begin
        if (w_wr_div[i]) begin
          r_div[i] <= writedata[DIV_WIDTH-1:0];
        end
      end
    end
  end

  always_comb begin
    readdata = '0;
    if (w_addr == REG_CONTROL) begin
      readdata[CHANNELS-1:0] = r_enable;
    end else if (w_addr == REG_STATUS) begin
      readdata[CHANNELS-1:0] = r_status;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (addr_is_divisor(w_addr, i)) begin
          readdata[DIV_WIDTH-1:0] = r_div[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_nios_sys_pio_clkdiv.sv
// Self-checking bench for nios_sys_pio_clkdiv: register map vectors plus
// directed timing sequences for ticks, square waves, status and reset.
module tb_nios_sys_pio_clkdiv;

  localparam int CH = 4;
  localparam int DW = 16;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] address = '0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = '0;
  logic [31:0]   readdata;
  logic [CH-1:0] tick;
  logic [CH-1:0] sq_out;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic        cs;
    logic        doWrite;
    int          addr;
    logic [31:0] wdata;
    logic [31:0] expRead;
  } vec_t;

  vec_t vecs[12];

  nios_sys_pio_clkdiv #(
    .CHANNELS      (CH),
    .DIV_WIDTH     (DW),
    .ADDR_WIDTH    (AW),
    .RESET_DIVISOR (0)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .tick       (tick),
    .sq_out     (sq_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic expTick(input int k, input int d);
    return (k > 0) && ((k % d) == 0);
  endfunction

  function automatic logic expSq(input int k, input int d);
    return ((k / d) % 2) == 1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%b expected=%b", name, got, exp);
    end
  endtask

  task automatic stepCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic busWrite(input int addr, input logic [31:0] data);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = AW'(addr);
    writedata  = data;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic busRead(input int addr, output logic [31:0] data);
    address = AW'(addr);
    #1;
    data = readdata;
  endtask

  task automatic applyStimulus(input vec_t v, output logic [31:0] rd);
    if (v.doWrite) begin
      chipselect = v.cs;
      write_n    = 1'b0;
      address    = AW'(v.addr);
      writedata  = v.wdata;
      @(posedge clk);
      #1;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
    end
    busRead(v.addr, rd);
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b1;
    stepCycles(1);
  endtask

  initial begin
    logic [31:0] rd;
    int e0;
    int e1;
    int k0;
    int k1;

    // cs, doWrite, addr, wdata, expected readback
    vecs[0]  = '{1'b0, 1'b0, 0, 32'h0000_0000, 32'h0000_0000};
    vecs[1]  = '{1'b0, 1'b0, 1, 32'h0000_0000, 32'h0000_0000};
    vecs[2]  = '{1'b0, 1'b0, 2, 32'h0000_0000, 32'h0000_0000};
    vecs[3]  = '{1'b0, 1'b0, 5, 32'h0000_0000, 32'h0000_0000};
    vecs[4]  = '{1'b0, 1'b0, 6, 32'h0000_0000, 32'h0000_0000};
    vecs[5]  = '{1'b0, 1'b0, 7, 32'h0000_0000, 32'h0000_0000};
    vecs[6]  = '{1'b1, 1'b1, 2, 32'h0000_1234, 32'h0000_1234};
    vecs[7]  = '{1'b1, 1'b1, 5, 32'hFFFF_5678, 32'h0000_5678};
    vecs[8]  = '{1'b0, 1'b1, 2, 32'h0000_0055, 32'h0000_1234};
    vecs[9]  = '{1'b1, 1'b1, 7, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[10] = '{1'b1, 1'b1, 0, 32'h0000_00F0, 32'h0000_0000};
    vecs[11] = '{1'b1, 1'b1, 1, 32'h0000_000F, 32'h0000_0000};

    $display("[TB] reset and register map");
    doReset();
    checkOutput("reset tick", 32'(tick), 32'h0);
    checkOutput("reset sq_out", 32'(sq_out), 32'h0);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i], rd);
      checkOutput($sformatf("vec%0d addr=%0d", i, vecs[i].addr), rd, vecs[i].expRead);
    end

    $display("[TB] channel 0 divisor 4");
    doReset();
    busWrite(2, 32'd4);
    busWrite(0, 32'h1);
    e0 = cyc;
    checkBit("ch0 tick k=0", tick[0], 1'b0);
    checkBit("ch0 sq k=0", sq_out[0], 1'b0);
    for (int k = 1; k <= 13; k++) begin
      stepCycles(1);
      checkBit($sformatf("ch0 tick k=%0d", k), tick[0], expTick(k, 4));
      checkBit($sformatf("ch0 sq k=%0d", k), sq_out[0], expSq(k, 4));
    end
    busRead(1, rd);
    checkOutput("status after ch0 ticks", rd, 32'h1);

    $display("[TB] channel 1 divisor 1 alongside channel 0");
    busWrite(3, 32'd1);
    busWrite(0, 32'h3);
    e1 = cyc;
    checkBit("ch1 tick k=0", tick[1], 1'b0);
    for (int j = 1; j <= 8; j++) begin
      stepCycles(1);
      k1 = cyc - e1;
      k0 = cyc - e0;
      checkBit($sformatf("ch1 tick k=%0d", k1), tick[1], 1'b1);
      checkBit($sformatf("ch1 sq k=%0d", k1), sq_out[1], k1[0]);
      checkBit($sformatf("ch0 tick k=%0d", k0), tick[0], expTick(k0, 4));
      checkBit($sformatf("ch0 sq k=%0d", k0), sq_out[0], expSq(k0, 4));
    end

    $display("[TB] divisor shrink mid-count");
    doReset();
    busWrite(2, 32'd100);
    busWrite(0, 32'h1);
    stepCycles(60);
    checkBit("ch0 tick before shrink", tick[0], 1'b0);
    busWrite(2, 32'd10);
    for (int k = 1; k <= 11; k++) begin
      stepCycles(1);
      checkBit($sformatf("shrink tick k=%0d", k), tick[0], k == 10);
      checkBit($sformatf("shrink sq k=%0d", k), sq_out[0], k >= 10);
    end

    $display("[TB] status clear versus coincident tick");
    doReset();
    busWrite(4, 32'd3);
    busWrite(0, 32'h4);
    stepCycles(3);
    checkBit("ch2 first tick", tick[2], 1'b1);
    busRead(1, rd);
    checkOutput("status after ch2 tick", rd, 32'h4);
    busWrite(1, 32'h4);
    busRead(1, rd);
    checkOutput("status plain clear", rd, 32'h0);
    stepCycles(1);
    busWrite(1, 32'h4);
    checkBit("ch2 coincident tick", tick[2], 1'b1);
    busRead(1, rd);
    checkOutput("status set wins", rd, 32'h4);
    busWrite(1, 32'h4);
    busRead(1, rd);
    checkOutput("status later clear", rd, 32'h0);

    $display("[TB] zero divisor and asynchronous reset");
    doReset();
    busWrite(0, 32'h8);
    for (int k = 1; k <= 10; k++) begin
      stepCycles(1);
      checkBit($sformatf("ch3 D=0 tick k=%0d", k), tick[3], 1'b0);
      checkBit($sformatf("ch3 D=0 sq k=%0d", k), sq_out[3], 1'b0);
    end
    busRead(1, rd);
    checkOutput("status with D=0", rd, 32'h0);
    busRead(0, rd);
    checkOutput("control with ch3", rd, 32'h8);
    busWrite(2, 32'd5);
    busWrite(0, 32'h9);
    stepCycles(7);
    checkBit("ch0 sq before reset", sq_out[0], 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("tick in reset", 32'(tick), 32'h0);
    checkOutput("sq_out in reset", 32'(sq_out), 32'h0);
    busRead(0, rd);
    checkOutput("control in reset", rd, 32'h0);
    #10;
    reset_n = 1'b1;
    stepCycles(1);
    checkOutput("tick first edge after reset", 32'(tick), 32'h0);
    checkOutput("sq_out first edge after reset", 32'(sq_out), 32'h0);
    busRead(0, rd);
    checkOutput("control after reset", rd, 32'h0);
    busRead(2, rd);
    checkOutput("divisor0 after reset", rd, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nios_sys_pio_clkdiv.md
Name: nios_sys_pio_clkdiv

Overview:
Avalon-MM slave that generalises the single 16-bit output PIO into CHANNELS independent programmable clock dividers. Each channel has a divisor register and an enable bit, and produces:
- a one-cycle tick;
- a divided square wave.

Intended use: stepper-motor step-rate generation and other timing off the Nios system clock. Software programs the registers and the counters then run in hardware.

Parameters:
CHANNELS, 4, number of divider channels (1..8); CHANNELS+2 <= 2**ADDR_WIDTH
DIV_WIDTH, 16, width of each divisor and counter (1..32)
ADDR_WIDTH, 3, Avalon word-address width
RESET_DIVISOR, 0, divisor value loaded into every channel at reset

Ports:
clk  input  1  system clock; all logic on rising edge
reset_n  input  1  asynchronous active-low reset
address  input  ADDR_WIDTH  register word address
chipselect  input  1  slave select
write_n  input  1  active-low write strobe
writedata  input  32  write data
readdata  output  32  read data, combinational from address, zero-extended
tick  output  CHANNELS  per-channel one-cycle pulse, registered
sq_out  output  CHANNELS  per-channel square wave (toggles on each tick), registered

Behaviour:
- Write qualifier: wr = chipselect & ~write_n. No read strobe; readdata is always driven from address.
- Register map:
  - 0 CONTROL: bit i = enable of channel i (R/W); upper bits read 0.
  - 1 STATUS: bit i = sticky tick flag of channel i. Write 1 clears the bit; write 0 has no effect.
  - 2+i DIVISOR[i]: R/W, uses writedata[DIV_WIDTH-1:0].
  - Unmapped addresses: read 0, writes ignored.
- Reset (async): per channel enable=0, cnt=0, tick=0, sq_out=0, status=0, divisor=RESET_DIVISOR. readdata follows the reset register values.
- Channel active = enable & (divisor != 0). Divisor 0 behaves exactly as disabled.
- Per active channel, each clk edge:
  - if cnt == divisor-1: cnt<=0, tick<=1, sq_out<=~sq_out, status bit<=1;
  - else: cnt<=cnt+1, tick<=0.
- Timing: the write edge E that activates a channel leaves cnt=0.
  - First tick is high in the cycle after edge E+D.
  - Tick period is D cycles and tick is high for exactly 1 cycle.
  - sq_out period is 2D cycles.
  - D=1: tick stays high continuously and sq_out toggles every cycle.
- Inactive channel (disabled or D=0): cnt<=0, tick<=0, sq_out<=0 on every edge. Status bit is retained.
- Enable 0->1 transition: counter starts from 0. Rewriting CONTROL with the bit already 1 does not restart the channel.
- DIVISOR[i] write: new value takes effect on the write edge; cnt<=0 and tick<=0 on that edge; sq_out keeps its level. This also covers writing a divisor smaller than the current cnt (no overrun or wrap past the limit).
- Simultaneous STATUS write-1-clear and tick on the same edge: set wins, so the bit reads 1.
- Counter arithmetic: unsigned DIV_WIDTH. No overflow, since cnt never exceeds divisor-1.
- Channels are fully independent; a write to one channel's divisor does not disturb any other channel.
- Reset asserted mid-count forces all state to reset values immediately. No tick is produced during reset or on the first edge after reset release.

Decomposition:
- Shared package nios_sys_pio_clkdiv_pkg: register offset constants (REG_CONTROL=0, REG_STATUS=1, REG_DIVISOR_BASE=2) and the per-channel address decode helper.
- Sub-module nios_sys_clkdiv_channel: one counter/tick/sq_out generator, with inputs enable, divisor, restart (divisor write or enable rise).
  - Instantiated CHANNELS times by generate.
  - The top module holds the register file, STATUS sticky logic and the read mux.

Test Plan:
- Reset then read all addresses -> CONTROL=0, STATUS=0, DIVISOR[i]=RESET_DIVISOR, address 7 reads 0; tick=0, sq_out=0.
- DIVISOR[0]=4, CONTROL=1 at edge E -> tick[0] high after edges E+4, E+8, E+12, one cycle each; sq_out[0] toggles at each tick (period 8); STATUS reads 0x1.
- DIVISOR[1]=1, enable ch1 -> tick[1] continuously high, sq_out[1] alternates 0/1 every cycle; ch0 timing unchanged.
- Ch0 running with D=100 and cnt=60, write DIVISOR[0]=10 -> next tick exactly 10 cycles after the write edge, with no 100-cycle gap.
- Ch2 D=3 enabled; write STATUS=0x4 on the same edge a tick occurs -> STATUS bit 2 remains 1. A later clear with no coincident tick reads 0.
- Enable ch3 D=0 -> no ticks, sq_out[3]=0. Assert reset_n low mid-count on ch0 -> tick/sq_out/cnt drop to 0 asynchronously and CONTROL reads 0 after release.
